// File: rtl/col_window_feeder_pkg.sv
// col_window_feeder_pkg: band marker values and feeder state encoding shared with the convolution integration.
package col_window_feeder_pkg;
    localparam int MARK_HDR  = 123;
    localparam int MARK_TRL0 = 124;
    localparam int MARK_TRL1 = 79;

    typedef enum logic [2:0] {FILL, HDR, PIX, TRL0, TRL1} state_t;

    function automatic logic [1:0] slot_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = 3'(a) + 3'(b);
        return 2'(s >= 3'd3 ? s - 3'd3 : s);
    endfunction
endpackage

// File: rtl/col_window_feeder_if.sv
// col_window_feeder_if: AXI-Stream beat channel with master/slave views.
interface col_window_feeder_if #(parameter int C_AXIS_TDATA_WIDTH = 32);
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                          tvalid;
    logic                          tready;
    logic                          tlast;

    modport master(output tdata, output tvalid, output tlast, input tready);
    modport slave(input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/col_window_feeder_ram.sv
// col_window_ram: simple dual-port line store with a one-cycle registered read.
module col_window_ram #(
    parameter int DEPTH = 192,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/col_window_feeder.sv
// col_window_feeder: buffers three image rows and streams each 3-row band column by column between marker beats.
module col_window_feeder
    import col_window_feeder_pkg::*;
#(
    parameter int IMG_WIDTH          = 64,
    parameter int IMG_HEIGHT         = 64,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_NB           = 8
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_areset,
    col_window_feeder_if.slave   s00_axis,
    col_window_feeder_if.master  m00_axis,
    output logic                 row_len_err
);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam int AW = $clog2(3 * IMG_WIDTH);

    state_t              state, state_n;
    logic [CW-1:0]       col, col_n, x, x_n;
    logic [1:0]          sub, sub_n, wr_slot, wr_slot_n, loaded, loaded_n;
    logic [RW-1:0]       row_in, row_in_n;
    logic                pix_last, pix_last_n, err_n;
    logic [DW-1:0]       tdata_n;
    logic                tvalid_n, tlast_n;
    logic                wr_en, beat_out, row_end, unused_data;
    logic [AW-1:0]       waddr, raddr;
    logic [PIXEL_NB-1:0] rdata;

    assign s00_axis.tready = state == FILL;
    assign wr_en       = s00_axis.tvalid && s00_axis.tready;
    assign beat_out    = m00_axis.tvalid && m00_axis.tready;
    assign row_end     = col == CW'(IMG_WIDTH - 1);
    assign unused_data = ^s00_axis.tdata;
    assign waddr       = AW'(int'(wr_slot) * IMG_WIDTH + int'(col));
    // Read address follows the next-state counters so rdata always matches the registered (x, sub).
    assign raddr       = AW'(int'(slot_add(wr_slot_n, sub_n)) * IMG_WIDTH + int'(x_n));

    col_window_ram #(.DEPTH(3 * IMG_WIDTH), .AW(AW), .DW(PIXEL_NB)) u_ram (
        .clk   (s00_axis_aclk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (s00_axis.tdata[PIXEL_NB-1:0]),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_n    = state;
        col_n      = col;
        x_n        = x;
        sub_n      = sub;
        wr_slot_n  = wr_slot;
        loaded_n   = loaded;
        row_in_n   = row_in;
        pix_last_n = pix_last;
        tdata_n    = m00_axis.tdata;
        tvalid_n   = m00_axis.tvalid;
        tlast_n    = m00_axis.tlast;
        err_n      = row_len_err || (wr_en && (s00_axis.tlast != row_end));
        case (state)
            FILL: if (wr_en) begin
                col_n = row_end ? '0 : col + 1'b1;
                if (row_end) begin
                    row_in_n  = row_in + 1'b1;
                    wr_slot_n = wr_slot == 2'd2 ? 2'd0 : wr_slot + 2'd1;
                    loaded_n  = loaded == 2'd3 ? 2'd3 : loaded + 2'd1;
                    if (loaded_n == 2'd3) begin
                        state_n    = HDR;
                        tdata_n    = DW'(MARK_HDR);
                        tvalid_n   = 1'b1;
                        x_n        = '0;
                        sub_n      = '0;
                        pix_last_n = 1'b0;
                    end
                end
            end
            HDR, PIX: if (beat_out) begin
                if (state == PIX && pix_last) begin
                    state_n = TRL0;
                    tdata_n = DW'(MARK_TRL0);
                end else begin
                    state_n    = PIX;
                    tdata_n    = DW'(rdata);
                    pix_last_n = x == CW'(IMG_WIDTH - 1) && sub == 2'd2;
                    sub_n      = sub == 2'd2 ? 2'd0 : sub + 2'd1;
                    x_n        = sub != 2'd2 ? x : (x == CW'(IMG_WIDTH - 1) ? '0 : x + 1'b1);
                end
            end
            TRL0: if (beat_out) begin
                state_n = TRL1;
                tdata_n = DW'(MARK_TRL1);
                tlast_n = 1'b1;
            end
            TRL1: if (beat_out) begin
                state_n  = FILL;
                tdata_n  = '0;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                if (row_in >= RW'(IMG_HEIGHT)) begin
                    row_in_n  = '0;
                    loaded_n  = '0;
                    wr_slot_n = '0;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state           <= FILL;
            col             <= '0;
            x               <= '0;
            sub             <= '0;
            wr_slot         <= '0;
            loaded          <= '0;
            row_in          <= '0;
            pix_last        <= 1'b0;
            row_len_err     <= 1'b0;
            m00_axis.tdata  <= '0;
            m00_axis.tvalid <= 1'b0;
            m00_axis.tlast  <= 1'b0;
        end else begin
            state           <= state_n;
            col             <= col_n;
            x               <= x_n;
            sub             <= sub_n;
            wr_slot         <= wr_slot_n;
            loaded          <= loaded_n;
            row_in          <= row_in_n;
            pix_last        <= pix_last_n;
            row_len_err     <= err_n;
            m00_axis.tdata  <= tdata_n;
            m00_axis.tvalid <= tvalid_n;
            m00_axis.tlast  <= tlast_n;
        end
    end
endmodule

// File: tb/tb_col_window_feeder.sv
// tb_col_window_feeder: directed bench for a 4-wide, 5-high feeder covering bands, stalls, row errors, frames and reset.
module tb_col_window_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int checks = 0;
    int failures = 0;

    logic [31:0] cap_d [32];
    logic        cap_l [32];
    int          cap_n, cap_rdy, cap_unst;

    always #5 clk = ~clk;

    col_window_feeder_if #(.C_AXIS_TDATA_WIDTH(32)) s_if ();
    col_window_feeder_if #(.C_AXIS_TDATA_WIDTH(32)) m_if ();

    col_window_feeder #(
        .IMG_WIDTH(4), .IMG_HEIGHT(5), .C_AXIS_TDATA_WIDTH(32), .PIXEL_NB(8)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis        (s_if),
        .m00_axis        (m_if),
        .row_len_err     (err)
    );

    // Expected beat i of a band whose oldest/middle/newest rows start at b0/b1/b2.
    function automatic int band_beat(input int i, input int b0, input int b1, input int b2);
        int k;
        if (i == 0) return 123;
        if (i == 13) return 124;
        if (i == 14) return 79;
        k = i - 1;
        return ((k % 3) == 0 ? b0 : (k % 3) == 1 ? b1 : b2) + k / 3;
    endfunction

    task automatic send_row(input int base, input int last_col);
        for (int c = 0; c < 4; c++) begin
            s_if.tdata  = 32'hDEAD_0000 | 32'(base + c);
            s_if.tvalid = 1'b1;
            s_if.tlast  = (c == last_col);
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic collect(input bit toggle, input int n);
        logic [31:0] pd;
        logic        pl;
        bit          pstall;
        int          cyc;
        pstall = 0; cyc = 0; pd = '0; pl = 1'b0;
        cap_n = 0; cap_rdy = 0; cap_unst = 0;
        while (cap_n < n && cyc < 300) begin
            m_if.tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (pstall && (m_if.tdata !== pd || m_if.tlast !== pl)) cap_unst++;
            if (m_if.tvalid && s_if.tready) cap_rdy++;
            if (m_if.tvalid && m_if.tready) begin
                cap_d[cap_n] = m_if.tdata;
                cap_l[cap_n] = m_if.tlast;
                cap_n++;
            end
            pstall = m_if.tvalid && !m_if.tready;
            pd = m_if.tdata;
            pl = m_if.tlast;
            @(posedge clk); #1;
            cyc++;
        end
        m_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%0d err=%b expected 0 0 0 0",
                     m_if.tvalid, m_if.tlast, m_if.tdata, err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready: got %b expected 1", s_if.tready);
        end
    endtask

    task automatic test_first_band();
        send_row(0, 3);
        send_row(10, 3);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            failures++;
            $display("FAIL two_rows_no_band: got valid=%b expected 0", m_if.tvalid);
        end
        send_row(20, 3);
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd123) begin
            failures++;
            $display("FAIL hdr_latency: got valid=%b data=%0d expected 1 123", m_if.tvalid, m_if.tdata);
        end
        collect(0, 15);
        checks++;
        if (cap_n !== 15) begin
            failures++;
            $display("FAIL band1_len: got %0d expected 15", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_d[i] !== 32'(band_beat(i, 0, 10, 20)) || cap_l[i] !== (i == 14)) begin
                failures++;
                $display("FAIL band1_beat%0d: got %0d/%b expected %0d/%b", i, cap_d[i], cap_l[i],
                         band_beat(i, 0, 10, 20), i == 14);
            end
        end
        checks++;
        if (cap_rdy !== 0) begin
            failures++;
            $display("FAIL band1_in_ready: got %0d ready cycles expected 0", cap_rdy);
        end
    endtask

    task automatic test_second_band();
        send_row(30, 3);
        collect(0, 15);
        checks++;
        if (cap_n !== 15) begin
            failures++;
            $display("FAIL band2_len: got %0d expected 15", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_d[i] !== 32'(band_beat(i, 10, 20, 30)) || cap_l[i] !== (i == 14)) begin
                failures++;
                $display("FAIL band2_beat%0d: got %0d/%b expected %0d/%b", i, cap_d[i], cap_l[i],
                         band_beat(i, 10, 20, 30), i == 14);
            end
        end
        checks++;
        if (cap_rdy !== 0) begin
            failures++;
            $display("FAIL band2_in_ready: got %0d ready cycles expected 0", cap_rdy);
        end
    endtask

    task automatic test_stall();
        send_row(40, 3);
        collect(1, 15);
        checks++;
        if (cap_n !== 15) begin
            failures++;
            $display("FAIL stall_len: got %0d expected 15", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_d[i] !== 32'(band_beat(i, 20, 30, 40)) || cap_l[i] !== (i == 14)) begin
                failures++;
                $display("FAIL stall_beat%0d: got %0d/%b expected %0d/%b", i, cap_d[i], cap_l[i],
                         band_beat(i, 20, 30, 40), i == 14);
            end
        end
        checks++;
        if (cap_unst !== 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d changes expected 0", cap_unst);
        end
    endtask

    task automatic test_row_len_err_new_frame();
        send_row(100, 2);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL row_len_err_set: got %b expected 1", err);
        end
        send_row(110, 3);
        checks++;
        if (m_if.tvalid !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL new_frame_two_rows: got valid=%b err=%b expected 0 1", m_if.tvalid, err);
        end
        send_row(120, 3);
        collect(0, 15);
        checks++;
        if (cap_n !== 15) begin
            failures++;
            $display("FAIL f2b1_len: got %0d expected 15", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_d[i] !== 32'(band_beat(i, 100, 110, 120)) || cap_l[i] !== (i == 14)) begin
                failures++;
                $display("FAIL f2b1_beat%0d: got %0d/%b expected %0d/%b", i, cap_d[i], cap_l[i],
                         band_beat(i, 100, 110, 120), i == 14);
            end
        end
        send_row(130, 3);
        collect(0, 15);
        send_row(140, 3);
        collect(0, 15);
        checks++;
        if (cap_n !== 15 || cap_d[1] !== 32'd120 || cap_d[3] !== 32'd140 || cap_d[12] !== 32'd143) begin
            failures++;
            $display("FAIL f2b3_content: got len=%0d d1=%0d d3=%0d d12=%0d expected 15 120 140 143",
                     cap_n, cap_d[1], cap_d[3], cap_d[12]);
        end
        send_row(200, 3);
        checks++;
        if (m_if.tvalid !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL frame_end_no_band: got valid=%b err=%b expected 0 1", m_if.tvalid, err);
        end
    endtask

    task automatic test_reset_mid_band();
        send_row(210, 3);
        send_row(220, 3);
        collect(0, 6);
        checks++;
        if (cap_n !== 6 || cap_d[5] !== 32'(band_beat(5, 200, 210, 220))) begin
            failures++;
            $display("FAIL partial_band: got len=%0d d5=%0d expected 6 %0d", cap_n, cap_d[5],
                     band_beat(5, 200, 210, 220));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_band_reset: got valid=%b data=%0d err=%b expected 0 0 0",
                     m_if.tvalid, m_if.tdata, err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_tready: got %b expected 1", s_if.tready);
        end
        send_row(60, 3);
        send_row(70, 3);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_two_rows: got valid=%b expected 0", m_if.tvalid);
        end
        send_row(80, 3);
        collect(0, 15);
        checks++;
        if (cap_n !== 15) begin
            failures++;
            $display("FAIL fresh_len: got %0d expected 15", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_d[i] !== 32'(band_beat(i, 60, 70, 80)) || cap_l[i] !== (i == 14)) begin
                failures++;
                $display("FAIL fresh_beat%0d: got %0d/%b expected %0d/%b", i, cap_d[i], cap_l[i],
                         band_beat(i, 60, 70, 80), i == 14);
            end
        end
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_first_band();
        test_second_band();
        test_stall();
        test_row_len_err_new_frame();
        test_reset_mid_band();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/col_window_feeder.md
COL_WINDOW_FEEDER -- requirements
Module: col_window_feeder

Interface
REQ-001 Clock/reset: one clock; reset is asynchronous and active-high.
REQ-002 Param IMG_WIDTH, default 64: pixels per image row (3..256).
REQ-003 Param IMG_HEIGHT, default 64: rows per frame (3..256).
REQ-004 Param C_AXIS_TDATA_WIDTH, default 32: stream data width, both ports.
REQ-005 Param PIXEL_NB, default 8: pixel width; pixel occupies tdata[PIXEL_NB-1:0].
REQ-006 s00_axis_aclk  in  1  sole clock for both ports.
REQ-007 s00_axis_areset  in  1  async active-high reset.
REQ-008 s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  raster pixel, row-major; upper bits ignored.
REQ-009 s00_axis_tvalid  in  1  input beat valid.
REQ-010 s00_axis_tready  out  1  input beat accepted when tvalid&tready.
REQ-011 s00_axis_tlast  in  1  end of row marker.
REQ-012 m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  band beat, zero-extended.
REQ-013 m00_axis_tvalid  out  1  output beat valid.
REQ-014 m00_axis_tready  in  1  downstream convolution stage ready.
REQ-015 m00_axis_tlast  out  1  last beat of band.
REQ-016 row_len_err  out  1  sticky: tlast disagreed with IMG_WIDTH.

Function
REQ-017 Block SHALL hold a 3-row circular line store (3*IMG_WIDTH pixels), one row slot overwritten per input row.
REQ-018 States SHALL be FILL, HDR, PIX, TRL0, TRL1; reset state FILL.
REQ-019 FILL: s00_axis_tready=1; pixels written at column counter col; at col=IMG_WIDTH-1 col wraps to 0, row_in increments.
REQ-020 FILL->HDR when the row completing makes rows_loaded>=3; otherwise stay FILL.
REQ-021 In HDR, PIX, TRL0, TRL1 s00_axis_tready SHALL be 0 (no input overlap with emission).
REQ-022 HDR emits one beat of value 123; PIX emits 3*IMG_WIDTH beats; TRL0 emits 124; TRL1 emits 79 with m00_axis_tlast=1.
REQ-023 PIX order: for column x=0..IMG_WIDTH-1, beats oldest row, middle row, newest row at column x (sub counter 0..2 inner, x outer).
REQ-024 State advances only on output handshake (m00_axis_tvalid&m00_axis_tready).
REQ-025 TRL1 handshake -> FILL if rows received < IMG_HEIGHT, else FILL with row_in, rows_loaded, slot pointer cleared (new frame).
REQ-026 Output SHALL be registered; first HDR beat valid 1 cycle after the completing input beat.
REQ-027 While m00_axis_tvalid=1 and m00_axis_tready=0, tdata/tlast SHALL stay stable; one beat per cycle at full throughput.
REQ-028 Input tlast at col!=IMG_WIDTH-1, or col=IMG_WIDTH-1 without tlast, SHALL set row_len_err; column counting ignores tlast.
REQ-029 Pixel values equal to 123/124/79 SHALL pass unmodified (no escaping).
REQ-030 Bands per frame SHALL equal IMG_HEIGHT-2.

Reset
REQ-031 On reset: state FILL, all counters 0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, row_len_err=0, s00_axis_tready=1 after release; line-store contents need not reset.
REQ-032 Reset mid-band SHALL abort emission immediately; next frame starts from FILL with row 0.

Structure
REQ-033 Shared package SHALL hold marker constants (123, 124, 79) and the state encoding typedef, common with convolution_v1_0 integration.
REQ-034 One sub-module natural: col_window_ram, simple dual-port 3*IMG_WIDTH x PIXEL_NB, 1-cycle synchronous read, address computed in parent.

Verification
REQ-035 IMG_WIDTH=4, rows 0..2 pixels r*10+c, tready=1 -> 123, 0,10,20, 1,11,21, 2,12,22, 3,13,23, 124, 79(tlast).
REQ-036 Fourth row 30..33 -> band 123, 10,20,30, ..., 13,23,33, 124, 79; input tready low during band.
REQ-037 m00_axis_tready toggled 1/0 each cycle during PIX -> identical beat sequence, no drops/duplicates, data stable while stalled.
REQ-038 tlast on column 2 of a 4-wide row -> row_len_err=1 and stays 1; band content unchanged.
REQ-039 Reset asserted at PIX beat 5 -> m00_axis_tvalid=0 next cycle, FILL, fresh frame of 3 rows yields correct first band.
REQ-040 IMG_HEIGHT=5 frame, then second frame -> exactly 3 bands per frame, second frame's first band uses only second-frame rows.
